// File: rtl/mult_unit.sv
// mult_unit: iterative signed multiplier for the EX stage.
// Handles the R-type mult instruction with radix-2 shift-add on operand
// magnitudes and fixes the sign at the end. The product goes into HI/LO.
// Upstream fetch/decode is stalled while the multiply is in flight.
module mult_unit #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] OP_MULT = 4'b1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        count_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic                 sign_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic                 accept;
  logic                 lastIter;
  logic [WIDTH-1:0]     absA_d;
  logic [WIDTH-1:0]     absB_d;
  logic [2*WIDTH-1:0]   addend_d;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   product_d;

  // Accept decode, operand magnitudes and the next shift-add step.
  // The most negative operand maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    accept    = (state_q == IDLE) && start && (alu_op == OP_MULT);
    lastIter  = (count_q == CW'(WIDTH - 1));
    absA_d    = a[WIDTH-1] ? -a : a;
    absB_d    = b[WIDTH-1] ? -b : b;
    addend_d  = {{WIDTH{1'b0}}, mcand_q} << count_q;
    acc_d     = mplier_q[0] ? (acc_q + addend_d) : acc_q;
    product_d = sign_q ? -acc_d : acc_d;
  end

  // Control FSM and datapath registers; HI/LO only move on the final iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      sign_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
            mcand_q  <= absA_d;
            mplier_q <= absB_d;
            acc_q    <= '0;
            count_q  <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CW'(1);
          if (lastIter) begin
            {hi_q, lo_q} <= product_d;
            state_q      <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = (state_q == BUSY);
  assign done  = (state_q == DONE);
  assign stall = accept || (state_q == BUSY);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: randomized self-checking bench for mult_unit.
// The reference result is the plain signed 64-bit product of the operands;
// HI/LO are expected to hold the last completed product (0 after reset).
module tb_mult_unit;

  localparam int         WIDTH   = 32;
  localparam logic [3:0] OP_MULT = 4'b1000;

  logic             clk;
  logic             rst;
  logic             start;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int vectors;
  int miscompares;
  logic [63:0] lastProduct;

  mult_unit #(
    .WIDTH  (WIDTH),
    .OP_MULT(OP_MULT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .alu_op(alu_op),
    .a     (a),
    .b     (b),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: full-precision signed product
  function automatic logic [63:0] refProduct(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return 64'(p);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic scrambleInputs();
    start  = 1'($urandom);
    alu_op = 4'($urandom);
    a      = $urandom;
    b      = $urandom;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the DONE cycle
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y);
    int busyCnt;
    int doneEarly;
    int stallLow;
    start  = 1'b1;
    alu_op = OP_MULT;
    a      = x;
    b      = y;
    #1 checkOutput("stall_accept", 64'(stall), 64'd1);
    @(posedge clk);
    #1 scrambleInputs();
    busyCnt   = 0;
    doneEarly = 0;
    stallLow  = 0;
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (done) doneEarly++;
      if (!stall) stallLow++;
      #1 scrambleInputs();
    end
    checkOutput("busy_cycles", 64'(busyCnt), 64'd32);
    checkOutput("done_early", 64'(doneEarly), 64'd0);
    checkOutput("stall_in_busy", 64'(stallLow), 64'd0);
    @(negedge clk);
    lastProduct = refProduct(x, y);
    checkOutput("done_pulse", 64'(done), 64'd1);
    checkOutput("busy_in_done", 64'(busy), 64'd0);
    checkOutput("stall_in_done", 64'(stall), 64'd0);
    checkOutput("hilo", {hi, lo}, lastProduct);
    start = 1'b0;
  endtask

  // One IDLE cycle after DONE: pulse over, result held
  task automatic idleCheck();
    @(negedge clk);
    checkOutput("done_dropped", 64'(done), 64'd0);
    checkOutput("busy_idle", 64'(busy), 64'd0);
    checkOutput("hilo_hold", {hi, lo}, lastProduct);
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  op;
    int doneSeen;
    int busySeen;
    int stallSeen;

    vectors     = 0;
    miscompares = 0;
    lastProduct = 64'd0;
    rst    = 1'b1;
    start  = 1'b0;
    alu_op = 4'd0;
    a      = '0;
    b      = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    checkOutput("reset_flags", {61'd0, stall, busy, done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases from the plan
    applyStimulus(32'd3, 32'd5);
    idleCheck();
    applyStimulus(32'hFFFF_FFFF, 32'd1);
    idleCheck();
    applyStimulus(32'h8000_0000, 32'h8000_0000);
    idleCheck();
    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF);
    idleCheck();
    applyStimulus(32'd0, 32'hFFFF_FFF9);
    idleCheck();

    // Non-mult op is ignored entirely
    start  = 1'b1;
    alu_op = 4'b0010;
    a      = 32'd7;
    b      = 32'd9;
    doneSeen  = 0;
    busySeen  = 0;
    stallSeen = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (done) doneSeen++;
      if (busy) busySeen++;
      if (stall) stallSeen++;
      @(negedge clk);
    end
    checkOutput("nonmult_stall", 64'(stallSeen), 64'd0);
    checkOutput("nonmult_busy", 64'(busySeen), 64'd0);
    checkOutput("nonmult_done", 64'(doneSeen), 64'd0);
    checkOutput("nonmult_hilo", {hi, lo}, lastProduct);
    start = 1'b0;

    // Operands scrambled mid-BUSY must not matter
    applyStimulus(32'd6, 32'd7);
    checkOutput("lo_42", 64'(lo), 64'd42);

    // A mult presented in DONE waits for the following IDLE cycle
    x = 32'hFFFF_FFF3;
    y = 32'd1000;
    start  = 1'b1;
    alu_op = OP_MULT;
    a      = x;
    b      = y;
    #1 checkOutput("no_accept_in_done", 64'(stall), 64'd0);
    @(negedge clk);
    checkOutput("idle_after_done", 64'({busy, done}), 64'd0);
    applyStimulus(x, y);
    idleCheck();

    // Asynchronous reset at iteration 10 aborts the multiply
    start  = 1'b1;
    alu_op = OP_MULT;
    a      = 32'd12345;
    b      = 32'd678;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    lastProduct = 64'd0;
    checkOutput("abort_flags", {61'd0, stall, busy, done}, 64'd0);
    checkOutput("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) doneSeen++;
    end
    checkOutput("abort_no_done", 64'(doneSeen), 64'd0);
    applyStimulus(32'hFFFF_FFFC, 32'hFFFF_FFFA);
    checkOutput("neg_neg_24", {hi, lo}, 64'd24);
    idleCheck();

    // Randomized multiplies, interleaved with ignored non-mult ops
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0:       x = 32'h8000_0000;
        1:       x = 32'($urandom_range(0, 15)) - 32'd8;
        default: x = $urandom;
      endcase
      y = $urandom;
      if (n % 5 == 0) y = 32'd0;
      op = 4'($urandom_range(0, 15));
      if (op != OP_MULT) begin
        start  = 1'b1;
        alu_op = op;
        a      = $urandom;
        b      = $urandom;
        #1 checkOutput("rand_nonmult_stall", 64'({stall, busy}), 64'd0);
        @(negedge clk);
        checkOutput("rand_nonmult_hilo", {hi, lo}, lastProduct);
      end
      applyStimulus(x, y);
      idleCheck();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
